// File: rtl/laa_if.sv
// ============================================================================
// Module      : laa_if
// Description : Host bus for the laa matrix-multiply engine.
//               The host (master) drives a command opcode, a register address
//               and write data; the engine (slave) returns registered read
//               data.
//   opcode   [1:0]        NONE=0, WRITE=1, READ=2, MULTIPLY=3
//   addr     [4:0]        register address
//   data_in  [DATA_W-1:0] write data
//   data_out [DATA_W-1:0] read data, valid one cycle after a READ
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface laa_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        opcode;
  logic [4:0]        addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (
    output opcode,
    output addr,
    output data_in,
    input  data_out
  );

  modport slave (
    input  opcode,
    input  addr,
    input  data_in,
    output data_out
  );
endinterface

`default_nettype wire

// File: rtl/laa.sv
// ============================================================================
// Module      : laa
// Description : Memory-mapped 3x3 unsigned integer matrix multiplier.
//               A (addr 0-8) and B (addr 9-17) are row-major register files.
//               MULTIPLY computes one element of A*B per cycle into a result
//               buffer (9 cycles), then copies the buffer into A in a single
//               commit cycle. STATUS (addr 31) = {.., done, busy}.
// Ports       : clk    - system clock, rising edge
//               reset  - synchronous, active-low
//               bus    - laa_if slave modport (opcode/addr/data_in/data_out)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module laa #(
  parameter int DATA_W = 32
) (
  input  wire   clk,
  input  wire   reset,
  laa_if.slave  bus
);

  localparam logic [1:0] OP_NONE     = 2'd0;
  localparam logic [1:0] OP_WRITE    = 2'd1;
  localparam logic [1:0] OP_READ     = 2'd2;
  localparam logic [1:0] OP_MULTIPLY = 2'd3;

  localparam logic [4:0] ADDR_STATUS = 5'd31;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [DATA_W-1:0] a_q [0:8];
  logic [DATA_W-1:0] a_d [0:8];
  logic [DATA_W-1:0] b_q [0:8];
  logic [DATA_W-1:0] b_d [0:8];
  logic [DATA_W-1:0] c_q [0:8];
  logic [DATA_W-1:0] c_d [0:8];

  // --------------------------------------------------------------------------
  // Dot product for element k: row i = k/3, column j = k%3.
  // row_base indexes A[i][0]; col indexes B[0][j].
  // --------------------------------------------------------------------------
  logic [3:0]        row_base;
  logic [3:0]        col;
  logic [DATA_W-1:0] prod0, prod1, prod2, dot;

  always_comb begin
    row_base = 4'd0;
    col      = 4'd0;
    case (k_q)
      4'd0: begin row_base = 4'd0; col = 4'd0; end
      4'd1: begin row_base = 4'd0; col = 4'd1; end
      4'd2: begin row_base = 4'd0; col = 4'd2; end
      4'd3: begin row_base = 4'd3; col = 4'd0; end
      4'd4: begin row_base = 4'd3; col = 4'd1; end
      4'd5: begin row_base = 4'd3; col = 4'd2; end
      4'd6: begin row_base = 4'd6; col = 4'd0; end
      4'd7: begin row_base = 4'd6; col = 4'd1; end
      4'd8: begin row_base = 4'd6; col = 4'd2; end
      default: begin row_base = 4'd0; col = 4'd0; end
    endcase
    // Products and sum deliberately truncate to DATA_W (modulo arithmetic).
    prod0 = a_q[row_base]        * b_q[col];
    prod1 = a_q[row_base + 4'd1] * b_q[col + 4'd3];
    prod2 = a_q[row_base + 4'd2] * b_q[col + 4'd6];
    dot   = prod0 + prod1 + prod2;
  end

  // --------------------------------------------------------------------------
  // Read mux. For addr 9..17, addr[3:0]-9 (mod 16) maps 9..15 -> 0..6 and
  // 16,17 -> 7,8, so the B index needs no 5-bit subtract.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] rd_val;
  logic [3:0]        b_idx;

  always_comb begin
    b_idx  = bus.addr[3:0] - 4'd9;
    rd_val = '0;
    if (bus.addr < 5'd9) begin
      rd_val = a_q[bus.addr[3:0]];
    end else if (bus.addr < 5'd18) begin
      rd_val = b_q[b_idx];
    end else if (bus.addr == ADDR_STATUS) begin
      rd_val = {{(DATA_W-2){1'b0}}, done_q, busy_q};
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    busy_d     = busy_q;
    done_d     = done_q;
    data_out_d = data_out_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;

    // Reads are honoured in every state and see pre-edge register contents.
    if (bus.opcode == OP_READ) begin
      data_out_d = rd_val;
    end

    case (state_q)
      IDLE: begin
        if (bus.opcode == OP_WRITE) begin
          if (bus.addr < 5'd9) begin
            a_d[bus.addr[3:0]] = bus.data_in;
            done_d             = 1'b0;
          end else if (bus.addr < 5'd18) begin
            b_d[b_idx] = bus.data_in;
            done_d     = 1'b0;
          end
        end else if (bus.opcode == OP_MULTIPLY) begin
          busy_d  = 1'b1;
          done_d  = 1'b0;
          k_d     = 4'd0;
          state_d = CALC;
        end
      end

      CALC: begin
        c_d[k_q] = dot;
        if (k_q == 4'd8) begin
          state_d = COMMIT;
        end else begin
          k_d = k_q + 4'd1;
        end
      end

      COMMIT: begin
        // A is only overwritten here, so every C element above was computed
        // from the original A.
        a_d     = c_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      k_q        <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
      for (int n = 0; n < 9; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
        c_q[n] <= '0;
      end
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
    end
  end

  assign bus.data_out = data_out_q;

  // OP_NONE needs no action: every register simply holds.
  logic unused_ok;
  assign unused_ok = (OP_NONE == 2'd0);

endmodule

`default_nettype wire

// File: tb/tb_laa.sv
// ============================================================================
// Module      : tb_laa
// Description : Self-checking bench for laa. Reads push the expected value to
//               a scoreboard queue; the checker pops and compares when the
//               registered read data appears one cycle later.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_laa;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  laa_if #(.DATA_W(32)) bus_if ();

  laa #(.DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  logic sb_rd   = 1'b0;
  logic rd_seen = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // A scoreboard read was sampled by the DUT at this edge.
  always @(posedge clk) rd_seen <= sb_rd && reset && (bus_if.opcode == 2'd2);

  always @(negedge clk) begin
    if (rd_seen) begin
      if (sb_q.size() == 0) begin
        check_val("sb_underflow", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check_val(e.tag, bus_if.data_out, e.exp);
      end
    end
  end

  task automatic cmd(input logic [1:0] op, input logic [4:0] a,
                     input logic [31:0] d);
    @(negedge clk);
    sb_rd          = 1'b0;
    bus_if.opcode  = op;
    bus_if.addr    = a;
    bus_if.data_in = d;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp,
                    input string tag);
    sb_t e;
    @(negedge clk);
    sb_rd         = 1'b1;
    bus_if.opcode = 2'd2;
    bus_if.addr   = a;
    e.tag = $sformatf("%s@%0d", tag, a);
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sb_rd         = 1'b0;
      bus_if.opcode = 2'd0;
    end
  endtask

  logic [31:0] mat_a [0:8];
  logic [31:0] mat_b [0:8];
  logic [31:0] prod_c [0:8];
  int          done_n;

  initial begin
    mat_a  = '{32'd3, 32'd12, 32'd4, 32'd5, 32'd6, 32'd8, 32'd1, 32'd0, 32'd2};
    mat_b  = '{32'd7, 32'd3, 32'd8, 32'd11, 32'd9, 32'd5, 32'd6, 32'd8, 32'd4};
    prod_c = '{32'd177, 32'd149, 32'd100, 32'd149, 32'd133, 32'd102,
               32'd19, 32'd19, 32'd16};

    reset          = 1'b0;
    bus_if.opcode  = 2'd0;
    bus_if.addr    = 5'd0;
    bus_if.data_in = 32'd0;
    idle(3);
    check_val("rst_dout", bus_if.data_out, 32'd0);
    reset = 1'b1;

    // Reset values
    rd(5'd0,  32'd0, "rst");
    rd(5'd9,  32'd0, "rst");
    rd(5'd17, 32'd0, "rst");
    rd(5'd31, 32'd0, "rst_status");

    // Load and read back
    for (int n = 0; n < 9; n++) cmd(2'd1, 5'(n), mat_a[n]);
    for (int n = 0; n < 9; n++) cmd(2'd1, 5'(n + 9), mat_b[n]);
    for (int n = 0; n < 9; n++) rd(5'(n), mat_a[n], "load_a");
    for (int n = 0; n < 9; n++) rd(5'(n + 9), mat_b[n], "load_b");
    idle(1);

    // MULTIPLY held two cycles (edges E0, E1), write during busy (E2),
    // then poll STATUS from E3 on.
    cmd(2'd3, 5'd0, 32'd0);
    cmd(2'd3, 5'd0, 32'd0);
    cmd(2'd1, 5'd0, 32'd999);
    cmd(2'd2, 5'd31, 32'd0);
    done_n = -1;
    for (int n = 3; n < 25; n++) begin
      @(negedge clk);
      if (n == 3) check_val("poll_busy", bus_if.data_out, 32'd1);
      if (bus_if.data_out == 32'd2) begin
        done_n = n;
        break;
      end
    end
    check_val("done_edge", 32'(done_n), 32'd11);
    idle(1);
    rd(5'd31, 32'd2, "status_done");

    for (int n = 0; n < 9; n++) rd(5'(n), prod_c[n], "prod");
    for (int n = 0; n < 9; n++) rd(5'(n + 9), mat_b[n], "b_kept");

    // Unmapped address
    cmd(2'd1, 5'd20, 32'hDEAD_BEEF);
    rd(5'd20, 32'd0, "unmapped");

    // Write to STATUS ignored; write to A clears done
    cmd(2'd1, 5'd31, 32'hFFFF_FFFF);
    rd(5'd31, 32'd2, "status_wr_ign");
    cmd(2'd1, 5'd8, 32'd0);
    rd(5'd31, 32'd0, "done_clr");

    // Wrap-around: (2^32-1)^2 mod 2^32 = 1
    for (int n = 0; n < 18; n++) cmd(2'd1, 5'(n), 32'd0);
    cmd(2'd1, 5'd0, 32'hFFFF_FFFF);
    cmd(2'd1, 5'd9, 32'hFFFF_FFFF);
    cmd(2'd3, 5'd0, 32'd0);
    idle(11);
    rd(5'd0, 32'd1, "wrap");
    rd(5'd1, 32'd0, "wrap");
    rd(5'd4, 32'd0, "wrap");
    rd(5'd9, 32'hFFFF_FFFF, "wrap_b");

    // Reset mid-CALC
    for (int n = 0; n < 9; n++) cmd(2'd1, 5'(n), mat_a[n]);
    for (int n = 0; n < 9; n++) cmd(2'd1, 5'(n + 9), mat_b[n]);
    cmd(2'd3, 5'd0, 32'd0);
    idle(4);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_val("midrst_dout", bus_if.data_out, 32'd0);
    idle(12);
    for (int n = 0; n < 18; n++) rd(5'(n), 32'd0, "midrst");
    rd(5'd31, 32'd0, "midrst_status");
    idle(2);

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
